// File: rtl/uart_rx_loader.sv
// Frame-level image loader behind the UART byte receiver.
// Frame: SYNC, len[15:8], len[7:0], len payload bytes, XOR checksum.
// Payload bytes go to memory from base_addr upward. Completion and errors are
// reported to the control unit.
module uart_rx_loader #(
  parameter int unsigned ADDR_W      = 16,
  parameter int unsigned MEM_DEPTH   = 65536,
  parameter logic [7:0]  SYNC_BYTE   = 8'hA5,
  parameter int unsigned TIMEOUT_CYC = 1000000
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic              abort,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic              rx_done_tick,
  input  logic [7:0]        rx_data,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  output logic              busy,
  output logic              done,
  output logic              err_chk,
  output logic              err_len,
  output logic              err_tmo,
  output logic [15:0]       byte_cnt
);

  localparam int unsigned TmrW      = $clog2(TIMEOUT_CYC + 1);
  localparam int unsigned SumW      = ADDR_W + 17;
  localparam logic [SumW-1:0] MemEnd = SumW'(MEM_DEPTH);
  localparam logic [TmrW-1:0] TmoVal = TmrW'(TIMEOUT_CYC);

  typedef enum logic [2:0] {
    StIdle, StSync, StLenHi, StLenLo, StLenChk, StPayload, StChk
  } state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [15:0]       len_q, len_d;
  logic [7:0]        chk_q, chk_d;
  logic [TmrW-1:0]   tmr_q, tmr_d;
  logic [15:0]       cnt_q, cnt_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [7:0]        mem_wdata_q, mem_wdata_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              err_chk_q, err_chk_d;
  logic              err_len_q, err_len_d;
  logic              err_tmo_q, err_tmo_d;

  logic [SumW-1:0] len_end;
  logic            len_ok;
  logic            timed;
  logic            pay_byte;

  // Range check of the received length; wide sum so base+len cannot wrap.
  always_comb begin
    len_end = SumW'(base_q) + SumW'(len_q);
    len_ok  = (len_q != 16'd0) && (len_end <= MemEnd);
    timed   = (state_q == StLenHi) || (state_q == StLenLo) || (state_q == StLenChk) ||
              (state_q == StPayload) || (state_q == StChk);
    // A payload byte may already arrive in the length-check cycle.
    pay_byte = rx_done_tick &&
               ((state_q == StPayload) || ((state_q == StLenChk) && len_ok));
  end

  // Next-state and registered-output logic.
  always_comb begin
    state_d     = state_q;
    base_d      = base_q;
    len_d       = len_q;
    chk_d       = chk_q;
    tmr_d       = '0;
    cnt_d       = cnt_q;
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    done_d      = 1'b0;
    err_chk_d   = err_chk_q;
    err_len_d   = err_len_q;
    err_tmo_d   = err_tmo_q;

    if (abort) begin
      state_d = StIdle;
    end else begin
      if (timed && !rx_done_tick) begin
        tmr_d = tmr_q + TmrW'(1);
      end

      unique case (state_q)
        StIdle: begin
          if (start) begin
            base_d    = base_addr;
            len_d     = '0;
            cnt_d     = '0;
            chk_d     = '0;
            err_chk_d = 1'b0;
            err_len_d = 1'b0;
            err_tmo_d = 1'b0;
            state_d   = StSync;
          end
        end
        StSync: begin
          if (rx_done_tick && (rx_data == SYNC_BYTE)) state_d = StLenHi;
        end
        StLenHi: begin
          if (rx_done_tick) begin
            len_d[15:8] = rx_data;
            state_d     = StLenLo;
          end
        end
        StLenLo: begin
          if (rx_done_tick) begin
            len_d[7:0] = rx_data;
            state_d    = StLenChk;
          end
        end
        StLenChk: begin
          if (len_ok) begin
            state_d = StPayload;
          end else begin
            err_len_d = 1'b1;
            state_d   = StIdle;
          end
        end
        StPayload: ;
        StChk: begin
          if (rx_done_tick) begin
            if (rx_data == chk_q) done_d    = 1'b1;
            else                  err_chk_d = 1'b1;
            state_d = StIdle;
          end
        end
        default: state_d = StIdle;
      endcase

      if (pay_byte) begin
        mem_we_d    = 1'b1;
        mem_addr_d  = base_q + ADDR_W'(cnt_q);
        mem_wdata_d = rx_data;
        chk_d       = chk_q ^ rx_data;
        cnt_d       = cnt_q + 16'd1;
        state_d     = (cnt_q + 16'd1 == len_q) ? StChk : StPayload;
      end

      if (timed && !rx_done_tick && (tmr_q + TmrW'(1) == TmoVal)) begin
        err_tmo_d = 1'b1;
        state_d   = StIdle;
      end
    end

    busy_d = (state_d != StIdle);
  end

  // State and output registers; reset cancels any pending write pulse.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= StIdle;
      base_q      <= '0;
      len_q       <= '0;
      chk_q       <= '0;
      tmr_q       <= '0;
      cnt_q       <= '0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_chk_q   <= 1'b0;
      err_len_q   <= 1'b0;
      err_tmo_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      base_q      <= base_d;
      len_q       <= len_d;
      chk_q       <= chk_d;
      tmr_q       <= tmr_d;
      cnt_q       <= cnt_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      err_chk_q   <= err_chk_d;
      err_len_q   <= err_len_d;
      err_tmo_q   <= err_tmo_d;
    end
  end

  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign err_chk   = err_chk_q;
  assign err_len   = err_len_q;
  assign err_tmo   = err_tmo_q;
  assign byte_cnt  = cnt_q;

endmodule

// File: tb/tb_uart_rx_loader.sv
// Self-checking bench for uart_rx_loader: table of frames, randomized frames
// against a frame-level reference model, and hand-written corner sequences.
module tb_uart_rx_loader;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic [15:0] base_addr = '0;
  logic        rx_done_tick = 1'b0;
  logic [7:0]  rx_data = '0;
  logic        mem_we;
  logic [15:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic        busy, done, err_chk, err_len, err_tmo;
  logic [15:0] byte_cnt;

  uart_rx_loader #(
    .ADDR_W      (16),
    .MEM_DEPTH   (65536),
    .SYNC_BYTE   (8'hA5),
    .TIMEOUT_CYC (50)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .start        (start),
    .abort        (abort),
    .base_addr    (base_addr),
    .rx_done_tick (rx_done_tick),
    .rx_data      (rx_data),
    .mem_we       (mem_we),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .busy         (busy),
    .done         (done),
    .err_chk      (err_chk),
    .err_len      (err_len),
    .err_tmo      (err_tmo),
    .byte_cnt     (byte_cnt)
  );

  always #5 clk = ~clk;

  // Observed activity: every write {addr,data}, its cycle, and done-high cycles.
  logic [23:0] writes[$];
  int          wcyc[$];
  int          done_cnt = 0;
  int          cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (mem_we) begin
      writes.push_back({mem_addr, mem_wdata});
      wcyc.push_back(cyc);
    end
    if (done) done_cnt = done_cnt + 1;
  end

  int n_checks = 0;
  int n_fail   = 0;
  int wr_base  = 0;
  int dn_base  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Frame-level reference: find sync, read length, apply range rule, XOR check.
  function automatic void model(input logic [15:0] base, input logic [7:0] b[$],
                                output logic [23:0] w[$], output int dn, output int ck,
                                output int ln, output int cnt);
    int i;
    int len;
    logic [7:0] x;
    w = {};
    dn = 0; ck = 0; ln = 0; cnt = 0; i = 0;
    while (i < b.size() && b[i] != 8'hA5) i++;
    i++;
    len = int'({b[i], b[i+1]});
    i += 2;
    if (len == 0 || int'(base) + len > 65536) begin
      ln = 1;
      return;
    end
    x = 8'h00;
    for (int k = 0; k < len; k++) begin
      w.push_back({base + 16'(k), b[i+k]});
      x = x ^ b[i+k];
    end
    cnt = len;
    if (b[i+len] == x) dn = 1;
    else               ck = 1;
  endfunction

  task automatic mark();
    wr_base = writes.size();
    dn_base = done_cnt;
  endtask

  task automatic pulse_start(input logic [15:0] b);
    @(negedge clk);
    start = 1'b1;
    base_addr = b;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] d, input int gap);
    repeat (gap) @(negedge clk);
    rx_done_tick = 1'b1;
    rx_data = d;
    @(negedge clk);
    rx_done_tick = 1'b0;
  endtask

  task automatic run_frame(input logic [15:0] base, input logic [7:0] q[$], input int maxgap);
    mark();
    pulse_start(base);
    foreach (q[i]) send_byte(q[i], $urandom_range(0, maxgap));
    repeat (4) @(negedge clk);
  endtask

  task automatic check_frame(input string tag, input int e_done, input int e_chk,
                             input int e_len, input int e_tmo, input int e_cnt,
                             input logic [23:0] ew[$]);
    int nw;
    nw = writes.size() - wr_base;
    chk({tag, ".done"}, done_cnt - dn_base, e_done);
    chk({tag, ".err_chk"}, err_chk, e_chk);
    chk({tag, ".err_len"}, err_len, e_len);
    chk({tag, ".err_tmo"}, err_tmo, e_tmo);
    chk({tag, ".byte_cnt"}, byte_cnt, e_cnt);
    chk({tag, ".busy"}, busy, 0);
    chk({tag, ".nwrites"}, nw, ew.size());
    for (int i = 0; i < nw && i < ew.size(); i++)
      chk({tag, ".write"}, writes[wr_base + i], ew[i]);
  endtask

  typedef struct {
    string       name;
    logic [15:0] base;
    int          n;
    logic [63:0] bytes;
    int          e_done;
    int          e_chk;
    int          e_len;
    int          e_cnt;
  } vec_t;

  vec_t        tbl[6];
  logic [7:0]  q[$];
  logic [23:0] ew[$];
  int          md, mc, ml, mcnt;

  initial begin
    tbl[0] = '{"good",    16'h0100, 7, 64'hA500_0311_2244_7700, 1, 0, 0, 3};
    tbl[1] = '{"badchk",  16'h0100, 7, 64'hA500_0311_2244_7600, 0, 1, 0, 3};
    tbl[2] = '{"lenover", 16'hFFFE, 6, 64'hA500_0311_2233_0000, 0, 0, 1, 0};
    tbl[3] = '{"lenzero", 16'h0000, 3, 64'hA500_0000_0000_0000, 0, 0, 1, 0};
    tbl[4] = '{"exactfit",16'hFFFF, 5, 64'hA500_019C_9C00_0000, 1, 0, 0, 1};
    tbl[5] = '{"hunt",    16'h0010, 6, 64'h00A5_0001_3C3D_0000, 0, 1, 0, 1};

    // Reset state.
    repeat (2) @(negedge clk);
    chk("rst.mem_we", mem_we, 0);
    chk("rst.mem_addr", mem_addr, 0);
    chk("rst.mem_wdata", mem_wdata, 0);
    chk("rst.busy", busy, 0);
    chk("rst.done", done, 0);
    chk("rst.errs", {err_chk, err_len, err_tmo}, 0);
    chk("rst.byte_cnt", byte_cnt, 0);
    reset_n = 1'b1;

    // start together with abort in IDLE stays idle; a stray byte in IDLE does nothing.
    @(negedge clk);
    start = 1'b1; abort = 1'b1; base_addr = 16'h1234;
    @(negedge clk);
    start = 1'b0; abort = 1'b0;
    send_byte(8'hA5, 0);
    @(negedge clk);
    chk("startabort.busy", busy, 0);
    chk("idle.nwrites", writes.size(), 0);

    // Table-driven frames.
    for (int t = 0; t < 6; t++) begin
      q = {};
      for (int k = 0; k < tbl[t].n; k++) q.push_back(tbl[t].bytes[63 - 8*k -: 8]);
      model(tbl[t].base, q, ew, md, mc, ml, mcnt);
      run_frame(tbl[t].base, q, 1);
      check_frame(tbl[t].name, tbl[t].e_done, tbl[t].e_chk, tbl[t].e_len, 0, tbl[t].e_cnt, ew);
    end

    // Randomized frames against the model.
    for (int r = 0; r < 24; r++) begin
      int len;
      logic [15:0] base;
      logic [7:0]  x, d;
      len = $urandom_range(0, 6);
      if (len >= 2 && $urandom_range(0, 3) == 0)
        base = 16'(65537 - len + $urandom_range(0, len - 2));
      else
        base = 16'($urandom_range(0, 65536 - (len == 0 ? 1 : len)));
      q = {};
      repeat ($urandom_range(0, 2)) begin
        d = 8'($urandom_range(0, 255));
        q.push_back(d == 8'hA5 ? 8'h00 : d);
      end
      q.push_back(8'hA5);
      q.push_back(8'h00);
      q.push_back(8'(len));
      x = 8'h00;
      for (int k = 0; k < len; k++) begin
        d = 8'($urandom_range(0, 255));
        q.push_back(d);
        x = x ^ d;
      end
      if ($urandom_range(0, 2) == 0) x = x ^ 8'($urandom_range(1, 255));
      q.push_back(x);
      model(base, q, ew, md, mc, ml, mcnt);
      run_frame(base, q, 2);
      check_frame("rand", md, mc, ml, 0, mcnt, ew);
    end

    // Sync hunt, start ignored while busy, then inter-byte timeout.
    mark();
    pulse_start(16'h0200);
    send_byte(8'h00, 1);
    send_byte(8'hFF, 1);
    send_byte(8'hA5, 1);
    @(negedge clk);
    start = 1'b1; base_addr = 16'h7777;
    @(negedge clk);
    start = 1'b0;
    send_byte(8'h00, 0);
    send_byte(8'h02, 1);
    send_byte(8'h55, 1);
    repeat (49) @(negedge clk);
    chk("tmo.early", err_tmo, 0);
    chk("tmo.busy_before", busy, 1);
    @(negedge clk);
    ew = {24'h020055};
    check_frame("tmo", 0, 0, 0, 1, 1, ew);

    // Back-to-back payload bytes, then abort together with a byte.
    mark();
    pulse_start(16'h0300);
    send_byte(8'hA5, 1);
    send_byte(8'h00, 1);
    send_byte(8'h04, 1);
    send_byte(8'hAA, 1);
    send_byte(8'hBB, 0);
    repeat (2) @(negedge clk);
    rx_done_tick = 1'b1; rx_data = 8'hCC; abort = 1'b1;
    @(negedge clk);
    rx_done_tick = 1'b0; abort = 1'b0;
    chk("abort.busy", busy, 0);
    chk("abort.mem_we", mem_we, 0);
    @(negedge clk);
    ew = {24'h0300AA, 24'h0301BB};
    check_frame("abort", 0, 0, 0, 0, 2, ew);
    if (writes.size() - wr_base == 2)
      chk("b2b.cycles", wcyc[wr_base + 1] - wcyc[wr_base], 1);
    else
      chk("b2b.count", writes.size() - wr_base, 2);

    // Asynchronous reset while a write pulse is on the bus.
    mark();
    pulse_start(16'h0400);
    send_byte(8'hA5, 1);
    send_byte(8'h00, 1);
    send_byte(8'h02, 1);
    send_byte(8'h11, 1);
    @(negedge clk);
    rx_done_tick = 1'b1; rx_data = 8'h22;
    @(posedge clk);
    #1 rx_done_tick = 1'b0;
    chk("rstmid.we_before", mem_we, 1);
    #2 reset_n = 1'b0;
    #1;
    chk("rstmid.mem_we", mem_we, 0);
    chk("rstmid.outs", {mem_addr, mem_wdata, busy, done, err_chk, err_len, err_tmo, byte_cnt}, 0);
    @(negedge clk);
    reset_n = 1'b1;
    chk("rstmid.nwrites", writes.size() - wr_base, 1);
    q = {8'hA5, 8'h00, 8'h01, 8'h5A, 8'h5A};
    run_frame(16'h0500, q, 1);
    ew = {24'h05005A};
    check_frame("afterrst", 1, 0, 0, 0, 1, ew);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_rx_loader.md
Name: uart_rx_loader

Overview:
- Frame-level controller sitting directly after the UART byte receiver (consumes its rx_done_tick/dout pair).
- Parses a framed image-load packet: SYNC byte, 16-bit length, N payload bytes, XOR checksum.
- Writes payload bytes sequentially into the image data memory starting at a programmable base address.
- Reports completion and errors to the processor control unit.

Parameters:
- ADDR_W, 16, memory address width in bits.
- MEM_DEPTH, 65536, number of writable bytes from address 0; limits the accepted length.
- SYNC_BYTE, 8'hA5, frame start marker.
- TIMEOUT_CYC, 1000000, maximum clk cycles allowed between consecutive bytes once a frame has started.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle arm pulse; honoured only in IDLE.
- abort  in  1  one-cycle cancel pulse; honoured in any state.
- base_addr  in  ADDR_W  first write address; sampled on an accepted start.
- rx_done_tick  in  1  byte-valid strobe from the UART receiver.
- rx_data  in  8  received byte; valid when rx_done_tick=1.
- mem_we  out  1  memory write strobe.
- mem_addr  out  ADDR_W  memory write address.
- mem_wdata  out  8  memory write data.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse on a good frame.
- err_chk  out  1  sticky; checksum mismatch.
- err_len  out  1  sticky; length is 0 or base_addr+len > MEM_DEPTH.
- err_tmo  out  1  sticky; inter-byte timeout.
- byte_cnt  out  16  payload bytes written in the current or last frame.

Behaviour:
- Reset (reset_n=0, asynchronous): state=IDLE, and every output is 0 (mem_we, mem_addr, mem_wdata, busy, done, all err_*, byte_cnt). Internal length, checksum and timer registers are also 0.
- All outputs are registered. Byte handling is synchronous to clk.
- States and transitions:
  - IDLE: on start, latch base_addr, clear byte_cnt, checksum and all err_*, go to SYNC.
  - SYNC: a byte equal to SYNC_BYTE goes to LEN_HI. Any other byte is discarded and the block stays in SYNC. The timeout is not armed in SYNC.
  - LEN_HI: the byte becomes len[15:8]; go to LEN_LO.
  - LEN_LO: the byte becomes len[7:0]. The length check runs in the following cycle:
    - If len==0, or base+len > MEM_DEPTH (evaluated at ADDR_W+1 bits, no wrap), set err_len and go to IDLE.
    - Otherwise go to PAYLOAD.
  - PAYLOAD: each byte produces mem_we=1 for exactly one cycle, in the cycle after the rx_done_tick.
    - mem_addr=base+byte_cnt and mem_wdata=byte.
    - checksum ^= byte, and byte_cnt increments in that same cycle.
    - After byte_cnt reaches len, go to CHK.
  - CHK: the byte is compared with the checksum.
    - Equal: pulse done for 1 cycle and go to IDLE.
    - Not equal: set err_chk and go to IDLE.
    - The payload already in memory is not rolled back.
- Timeout: a counter is cleared on every rx_done_tick and increments each cycle in LEN_HI, LEN_LO, PAYLOAD and CHK. Reaching TIMEOUT_CYC sets err_tmo and goes to IDLE.
- Abort: the block goes to IDLE next cycle with no done and no error flag. If abort coincides with rx_done_tick, the byte is dropped and no mem_we is issued.
- start while busy is ignored. start coinciding with abort in IDLE gives priority to abort (stay IDLE).
- rx_done_tick in IDLE is ignored.
- Back-to-back rx_done_tick on consecutive cycles must be handled; each produces its own mem_we.
- mem_addr does not wrap, because the length check guarantees the frame fits.
- byte_cnt holds its value after frame end until the next accepted start.
- Async reset mid-frame: immediate return to IDLE; a partial write pulse in that cycle is cancelled.

Test Plan:
- Good frame: start with base=0x0100, then bytes A5 00 03 11 22 44 77. Writes must be 0x0100=11, 0x0101=22, 0x0102=44. Expect done pulse, byte_cnt=3, and no error flag.
- Bad checksum: same frame but last byte 0x76. Expect 3 writes, err_chk=1, no done, busy=0 afterwards.
- Length error: base=0xFFFE, frame A5 00 03 …, MEM_DEPTH=65536. Expect err_len=1, zero mem_we, return to IDLE.
- Sync hunt and timeout: bytes 00 FF A5 00 02 55, then silence with TIMEOUT_CYC=50. Expect the first two bytes ignored, one write of 55, err_tmo=1 at the 50th idle cycle, no done.
- Abort and back-to-back: A5 00 04, then two rx_done_tick on consecutive cycles (AA, BB) giving two writes on consecutive cycles. Then abort coinciding with a third tick: no third write, IDLE next cycle, all err_*=0.
- Reset mid-payload: assert reset_n=0 asynchronously after 1 payload byte. Expect all outputs 0 immediately. A later start with frame A5 00 01 5A 5A completes with done.
